// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b type definitions used by the memory arbiter.
// Word and write-mask widths, arbiter FSM states and port identifiers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } lc3b_arb_state;

    typedef enum logic {
        ARB_I,
        ARB_D
    } lc3b_arb_port;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational grant selection between the instruction and data ports.
// A lone requester always wins; on contention the port that did not win
// last time is chosen (a constant last_grant of ARB_I gives fixed D priority).
module mem_arbiter_select
    import lc3b_types::*;
(
    input  logic         i_req,
    input  logic         d_req,
    input  lc3b_arb_port last_grant,
    output logic         grant_valid,
    output lc3b_arb_port grant_port
);

    // Pick the winning port from the current request lines.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_port  = ARB_D;
        if (i_req && !d_req) begin
            grant_port = ARB_I;
        end else if (i_req && d_req && (last_grant == ARB_D)) begin
            grant_port = ARB_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: serialises I-fetch and D-memory word requests onto
// one physical-memory port and routes the completion back to the owner.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contested requests
// (default build uses fixed data-port priority).
module mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,

    input  logic          i_mem_read,
    input  lc3b_word      i_mem_address,
    output lc3b_word      i_mem_rdata,
    output logic          i_mem_resp,

    input  logic          d_mem_read,
    input  logic          d_mem_write,
    input  lc3b_word      d_mem_address,
    input  lc3b_word      d_mem_wdata,
    input  lc3b_mem_wmask d_mem_byte_enable,
    output lc3b_word      d_mem_rdata,
    output logic          d_mem_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state state;
    lc3b_arb_state state_next;

    lc3b_word      lat_addr;
    lc3b_word      lat_wdata;
    lc3b_mem_wmask lat_mask;
    logic          lat_write;

    logic          d_req;
    logic          grant_valid;
    lc3b_arb_port  grant_port;
    lc3b_arb_port  last_grant;
    logic          grant_now;

    // Simultaneous read+write on the data port is treated as a write.
    assign d_req     = d_mem_read | d_mem_write;
    assign grant_now = (state == IDLE) && grant_valid;

    mem_arbiter_select u_select (
        .i_req       (i_mem_read),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recent winner; reset value makes the first contest go to D.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ARB_I;
        end else if (grant_now) begin
            last_grant <= grant_port;
        end
    end
`else
    assign last_grant = ARB_I;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: grant from IDLE, return to IDLE on the memory completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_port == ARB_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the granted request so the physical port sees stable values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mask  <= '0;
            lat_write <= 1'b0;
        end else if (grant_now) begin
            if (grant_port == ARB_D) begin
                lat_addr  <= d_mem_address;
                lat_wdata <= d_mem_wdata;
                lat_mask  <= d_mem_byte_enable;
                lat_write <= d_mem_write;
            end else begin
                lat_addr  <= i_mem_address;
                lat_wdata <= '0;
                lat_mask  <= '0;
                lat_write <= 1'b0;
            end
        end
    end

    // Drive the physical port from the latches and route completion to the owner.
    // Responses are suppressed during reset so an aborted transaction never completes.
    always_comb begin
        pmem_read        = (state != IDLE) && !lat_write;
        pmem_write       = (state != IDLE) &&  lat_write;
        pmem_address     = lat_addr;
        pmem_wdata       = lat_wdata;
        pmem_byte_enable = lat_mask;
        i_mem_resp       = (state == I_BUSY) && pmem_resp && !reset;
        d_mem_resp       = (state == D_BUSY) && pmem_resp && !reset;
        i_mem_rdata      = (state == I_BUSY) ? pmem_rdata : '0;
        d_mem_rdata      = (state == D_BUSY) ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .i_mem_read        (i_mem_read),
        .i_mem_address     (i_mem_address),
        .i_mem_rdata       (i_mem_rdata),
        .i_mem_resp        (i_mem_resp),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding physical transaction at most; it carries the owner and
    // the request captured when it was granted.
    typedef struct {
        bit          active;
        bit          owner_d;
        bit          write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
    } txn_t;

    txn_t cur;
    bit   last_won_d;

    always @(posedge clk) begin
        bit want_i, want_d, pick_d;
        want_i = i_mem_read;
        want_d = d_mem_read | d_mem_write;
        if (reset) begin
            cur        = '{1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b0};
            last_won_d = 1'b0;
        end else if (cur.active) begin
            if (pmem_resp) cur.active = 1'b0;
        end else if (want_i || want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = want_d && (!want_i || !last_won_d);
`else
            pick_d = want_d;
`endif
            last_won_d = pick_d;
            if (pick_d)
                cur = '{1'b1, 1'b1, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable};
            else
                cur = '{1'b1, 1'b0, 1'b0, i_mem_address, cur.wdata, cur.mask};
        end
    end

    // Compare every cycle, midway between rising edges.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_i, exp_d;
            exp_i = cur.active && !cur.owner_d && pmem_resp && !reset;
            exp_d = cur.active &&  cur.owner_d && pmem_resp && !reset;
            check("pmem_read",  pmem_read,  cur.active && !cur.write);
            check("pmem_write", pmem_write, cur.active &&  cur.write);
            check("pmem_address", pmem_address, cur.addr);
            if (cur.active && cur.write) begin
                check("pmem_wdata", pmem_wdata, cur.wdata);
                check("pmem_byte_enable", pmem_byte_enable, cur.mask);
            end
            check("i_mem_resp", i_mem_resp, exp_i);
            check("d_mem_resp", d_mem_resp, exp_d);
            if (exp_i) check("i_mem_rdata", i_mem_rdata, pmem_rdata);
            if (exp_d) check("d_mem_rdata", d_mem_rdata, pmem_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_mem_read = 0; i_mem_address = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_address = '0;
        d_mem_wdata = '0; d_mem_byte_enable = '0;
        pmem_rdata = '0; pmem_resp = 0;
    endtask

    initial begin
        bit ir, dr;
        int k;
        reset = 1'b1;
        clear_inputs();
        step();
        chk_en = 1'b1;
        step();
        check("reset pmem_address", pmem_address, 16'h0000);
        check("reset pmem_wdata", pmem_wdata, 16'h0000);
        check("reset i_mem_rdata", i_mem_rdata, 16'h0000);
        check("reset pmem_read", pmem_read, 1'b0);
        reset = 1'b0;

        // Contested request: D first, I granted in the turnaround cycle.
        step();
        i_mem_read = 1; i_mem_address = 16'h0100;
        d_mem_read = 1; d_mem_address = 16'h0200;
        step();
        check("contest first addr", pmem_address, 16'h0200);
        pmem_resp = 1; pmem_rdata = 16'h5A5A;
        #1;
        check("contest d_resp", d_mem_resp, 1'b1);
        check("contest i_resp held", i_mem_resp, 1'b0);
        step();
        pmem_resp = 0; d_mem_read = 0;
        #1;
        check("turnaround idle", pmem_read, 1'b0);
        step();
        check("contest second addr", pmem_address, 16'h0100);
        pmem_resp = 1; pmem_rdata = 16'hCAFE;
        #1;
        check("contest i_resp", i_mem_resp, 1'b1);
        check("contest i_rdata", i_mem_rdata, 16'hCAFE);
        step();
        pmem_resp = 0; i_mem_read = 0;

        // Single I read with a 3-cycle memory.
        step();
        i_mem_read = 1; i_mem_address = 16'h0040;
        step();
        check("iread pmem_read", pmem_read, 1'b1);
        check("iread addr", pmem_address, 16'h0040);
        step();
        step();
        pmem_resp = 1; pmem_rdata = 16'h1234;
        #1;
        check("iread resp", i_mem_resp, 1'b1);
        check("iread rdata", i_mem_rdata, 16'h1234);
        check("iread d_resp", d_mem_resp, 1'b0);
        step();
        pmem_resp = 0; i_mem_read = 0;

        // D write held until completion.
        step();
        d_mem_write = 1; d_mem_address = 16'h2000; d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b01;
        step();
        check("dwrite pmem_write", pmem_write, 1'b1);
        check("dwrite addr", pmem_address, 16'h2000);
        check("dwrite wdata", pmem_wdata, 16'hBEEF);
        check("dwrite mask", pmem_byte_enable, 2'b01);
        step();
        check("dwrite held", pmem_write, 1'b1);
        pmem_resp = 1;
        #1;
        check("dwrite resp", d_mem_resp, 1'b1);
        step();
        pmem_resp = 0; d_mem_write = 0;
        #1;
        check("dwrite resp once", d_mem_resp, 1'b0);

        // Reset during D_BUSY with a completion in the reset cycle.
        step();
        d_mem_read = 1; d_mem_address = 16'h3000;
        step();
        check("rst busy pmem_read", pmem_read, 1'b1);
        reset = 1; pmem_resp = 1;
        #1;
        check("rst no d_resp", d_mem_resp, 1'b0);
        step();
        reset = 0; pmem_resp = 0; d_mem_read = 0;
        #1;
        check("rst pmem_read", pmem_read, 1'b0);
        check("rst pmem_write", pmem_write, 1'b0);

        // Spurious completion while idle.
        step();
        pmem_resp = 1;
        #1;
        check("idle resp i", i_mem_resp, 1'b0);
        check("idle resp d", d_mem_resp, 1'b0);
        step();
        pmem_resp = 0;
        #1;
        check("idle stays", pmem_read | pmem_write, 1'b0);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            ir = i_mem_resp;
            dr = d_mem_resp;
            step();
            reset = ($urandom % 64) == 0;
            if (ir) i_mem_read = 0;
            else if (!i_mem_read && ($urandom % 3) == 0) begin
                i_mem_read = 1; i_mem_address = 16'($urandom);
            end
            if (dr) begin
                d_mem_read = 0; d_mem_write = 0;
            end else if (!(d_mem_read || d_mem_write) && ($urandom % 3) == 0) begin
                k = int'($urandom % 8);
                d_mem_write = (k < 3) || (k == 7);
                d_mem_read  = (k >= 3);
                d_mem_address = 16'($urandom);
                d_mem_wdata = 16'($urandom);
                d_mem_byte_enable = 2'($urandom);
            end
            pmem_rdata = 16'($urandom);
            pmem_resp = (pmem_read || pmem_write) ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
        end

        step();
        clear_inputs();
        reset = 0;
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
